grf: RTL and testbench



---
 rtl/grf.sv | 61 ++++++
 tb/tb_grf.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/grf.sv
// 32 x 32-bit MIPS general register file: two combinational read ports, one synchronous write port.
// Optional same-cycle write-through forwarding is enabled by defining GRF_BYPASS_EN.
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    input  logic [4:0]  WA,
    input  logic [31:0] WD,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic [31:0] WPC
);

    logic [31:0] regs [32];
    logic        wr_en;

    // Entry 0 is cleared by reset and never written, so it stays 0.
    assign wr_en = reset && RegWrite && (WA != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[WA] <= WD;
        end
    end

`ifdef GRF_BYPASS_EN
    always_comb begin
        RD1 = 32'd0;
        RD2 = 32'd0;
        if (reset) begin
            if (RA1 != 5'd0) RD1 = (wr_en && (RA1 == WA)) ? WD : regs[RA1];
            if (RA2 != 5'd0) RD2 = (wr_en && (RA2 == WA)) ? WD : regs[RA2];
        end
    end
`else
    always_comb begin
        RD1 = 32'd0;
        RD2 = 32'd0;
        if (reset) begin
            if (RA1 != 5'd0) RD1 = regs[RA1];
            if (RA2 != 5'd0) RD2 = regs[RA2];
        end
    end
`endif

`ifndef SYNTHESIS
    // Write trace for comparison against the reference MIPS simulator log.
    always @(posedge clk) begin
        if (wr_en) begin
            $display("@%h: $%0d <= %h", WPC, WA, WD);
        end
    end
`endif

endmodule

// File: tb/tb_grf.sv
// Directed self-checking bench for grf; expectations follow GRF_BYPASS_EN when defined.
module tb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  RA1, RA2, WA;
    logic [31:0] WD, WPC;
    logic [31:0] RD1, RD2;

    int checks = 0;
    int errors = 0;

    grf dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .RA1(RA1), .RA2(RA2), .WA(WA), .WD(WD),
        .RD1(RD1), .RD2(RD2), .WPC(WPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        RegWrite = 1'b1;
        WA = a;
        WD = d;
        WPC = pc;
        tick();
        RegWrite = 1'b0;
        WD = 32'hx;
        WPC = 32'hx;
    endtask

    initial begin
        reset = 1'b0;
        RegWrite = 1'b0;
        RA1 = 5'd5;
        RA2 = 5'd31;
        WA = 5'd0;
        WD = 32'd0;
        WPC = 32'd0;
        #1;
        chk("reset_rd1", RD1, 32'd0);
        chk("reset_rd2", RD2, 32'd0);

        // Writes are blocked while reset is low, including bypass.
        RegWrite = 1'b1;
        WA = 5'd5;
        WD = 32'hCAFEF00D;
        #1;
        chk("reset_no_bypass", RD1, 32'd0);
        tick();
        chk("reset_blocks_write", RD1, 32'd0);
        RegWrite = 1'b0;

        // Release mid-cycle; the next edge is the first that writes.
        reset = 1'b1;
        #1;
        chk("after_release_empty", RD1, 32'd0);
        wr(5'd5, 32'hDEADBEEF, 32'h00003000);
        chk("write5", RD1, 32'hDEADBEEF);

        // Async reset pulse between edges clears immediately.
        #1;
        reset = 1'b0;
        #1;
        chk("async_clear_rd1", RD1, 32'd0);
        reset = 1'b1;
        #1;
        chk("async_clear_hold", RD1, 32'd0);

        wr(5'd31, 32'h00003004, 32'h00003000);
        chk("basic_rd2", RD2, 32'h00003004);

        // $0 is immutable, bypass path included.
        RA1 = 5'd0;
        RegWrite = 1'b1;
        WA = 5'd0;
        WD = 32'hFFFFFFFF;
        WPC = 32'h00003008;
        #1;
        chk("zero_pre_edge", RD1, 32'd0);
        tick();
        RegWrite = 1'b0;
        chk("zero_post_edge", RD1, 32'd0);

        // Write disabled with X data.
        wr(5'd8, 32'h12345678, 32'h0000300C);
        RA1 = 5'd8;
        WA = 5'd8;
        WD = 32'hx;
        tick();
        chk("wr_disabled", RD1, 32'h12345678);

        // Same-cycle read/write of $9.
        wr(5'd9, 32'd1, 32'h00003010);
        RA1 = 5'd9;
        RA2 = 5'd9;
        RegWrite = 1'b1;
        WA = 5'd9;
        WD = 32'd2;
        WPC = 32'h00003014;
        #1;
`ifdef GRF_BYPASS_EN
        chk("same_cycle_rd1_pre", RD1, 32'd2);
        chk("same_cycle_rd2_pre", RD2, 32'd2);
`else
        chk("same_cycle_rd1_pre", RD1, 32'd1);
        chk("same_cycle_rd2_pre", RD2, 32'd1);
`endif
        tick();
        RegWrite = 1'b0;
        chk("same_cycle_rd1_post", RD1, 32'd2);
        chk("same_cycle_rd2_post", RD2, 32'd2);

        // Reset asserted after an edge wipes that edge's write.
        wr(5'd10, 32'h00000055, 32'h00003018);
        RA1 = 5'd10;
        #1;
        chk("pre_wipe", RD1, 32'h00000055);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("wiped", RD1, 32'd0);
        RA2 = 5'd9;
        #1;
        chk("wiped_other", RD2, 32'd0);

        // Full sweep.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101, 32'h00004000 + 32'(4 * i));
        end
        for (int i = 1; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(32 - i);
            #1;
            chk($sformatf("sweep_rd1_%0d", i), RD1, 32'(i) * 32'h01010101);
            chk($sformatf("sweep_rd2_%0d", 32 - i), RD2, 32'(32 - i) * 32'h01010101);
        end
        RA1 = 5'd0;
        RA2 = 5'd0;
        #1;
        chk("sweep_zero_rd1", RD1, 32'd0);
        chk("sweep_zero_rd2", RD2, 32'd0);
        RA1 = 5'd17;
        RA2 = 5'd17;
        #1;
        chk("same_addr_rd1", RD1, 32'h11111111);
        chk("same_addr_rd2", RD2, 32'h11111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
